// File: rtl/msk_frame_sync_ber.sv
// Frame synchroniser and BER monitor for a sliced MSK bit stream carrying a known repeating pattern.
// Finds the sync word in either polarity, verifies one frame, then tracks bit and frame errors while locked.
module msk_frame_sync_ber #(
   parameter int             FDW         = 256,
   parameter logic [FDW-1:0] FIXED_DATA  = '0,
   parameter int             SYNC_W      = 32,
   parameter int             SYNC_ERR    = 0,
   parameter bit             INVERT_OK   = 1'b1,
   parameter int             LOSS_THRESH = 16,
   parameter int             LOSS_FRAMES = 2,
   parameter int             CNT_W       = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     data_i,
   input  logic                     data_val_i,
   input  logic                     clr_i,
   output logic [1:0]               state_o,
   output logic                     locked_o,
   output logic                     inverted_o,
   output logic                     bit_err_o,
   output logic                     frame_o,
   output logic [$clog2(FDW+1)-1:0] frame_err_cnt_o,
   output logic [CNT_W-1:0]         tot_bits_o,
   output logic [CNT_W-1:0]         tot_err_o
);

   localparam int PW = $clog2(FDW);
   localparam int EW = $clog2(FDW + 1);
   localparam int DW = $clog2(SYNC_W + 1);
   localparam int BW = $clog2(LOSS_FRAMES + 1);

   localparam logic [SYNC_W-1:0] SYNC_WORD = FIXED_DATA[FDW-1 -: SYNC_W];
   localparam logic [PW-1:0]     PTR_LAST  = PW'(FDW - 1);
   localparam logic [PW-1:0]     PTR_SYNC  = PW'(SYNC_W);
   localparam logic [PW-1:0]     PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
   localparam logic [BW-1:0]     BAD_ONE   = {{(BW-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   function automatic logic [FDW-1:0] bit_reverse(input logic [FDW-1:0] v);
      logic [FDW-1:0] r;
      r = '0;
      for (int i = 0; i < FDW; i++) begin
         r[i] = v[FDW-1-i];
      end
      return r;
   endfunction

   function automatic logic [DW-1:0] hamming(input logic [SYNC_W-1:0] v);
      logic [DW-1:0] c;
      c = '0;
      for (int i = 0; i < SYNC_W; i++) begin
         c = c + {{(DW-1){1'b0}}, v[i]};
      end
      return c;
   endfunction

   // Pattern reversed so that the bit expected at pointer p sits at index p.
   localparam logic [FDW-1:0] REF_LSB = bit_reverse(FIXED_DATA);

   state_t            state_r, state_s;
   logic [SYNC_W-1:0] sreg_r, sreg_s;
   logic [PW-1:0]     ptr_r, ptr_s;
   logic              inv_r, inv_s;
   logic [EW-1:0]     acc_r, acc_s;
   logic [BW-1:0]     bad_r, bad_s;
   logic              bit_err_r, bit_err_s;
   logic              frame_r, frame_s;
   logic              locked_r, locked_s;
   logic [EW-1:0]     fec_r, fec_s;
   logic [CNT_W-1:0]  tot_bits_r, tot_bits_s;
   logic [CNT_W-1:0]  tot_err_r, tot_err_s;

   logic [SYNC_W-1:0] sreg_shift_s;
   logic [DW-1:0]     dist_norm_s;
   logic [DW-1:0]     dist_inv_s;
   logic              exp_bit_s;
   logic              mismatch_s;
   logic [EW-1:0]     acc_inc_s;
   logic              bad_frame_s;
   logic              cnt_bit_s;
   logic              cnt_err_s;

   assign sreg_shift_s = {sreg_r[SYNC_W-2:0], data_i};
   assign dist_norm_s  = hamming(sreg_shift_s ^ SYNC_WORD);
   assign dist_inv_s   = hamming(sreg_shift_s ^ ~SYNC_WORD);
   assign exp_bit_s    = REF_LSB[ptr_r] ^ inv_r;
   assign mismatch_s   = data_i ^ exp_bit_s;
   assign acc_inc_s    = acc_r + {{(EW-1){1'b0}}, mismatch_s};
   assign bad_frame_s  = int'(acc_inc_s) > LOSS_THRESH;

   // Next-state, pointer, error accumulation and counter update logic.
   always_comb begin
      state_s   = state_r;
      sreg_s    = sreg_r;
      ptr_s     = ptr_r;
      inv_s     = inv_r;
      acc_s     = acc_r;
      bad_s     = bad_r;
      bit_err_s = 1'b0;
      frame_s   = 1'b0;
      cnt_bit_s = 1'b0;
      cnt_err_s = 1'b0;

      if (data_val_i) begin
         sreg_s = sreg_shift_s;
         case (state_r)
            ST_SEARCH: begin
               // Normal polarity is tested first so it wins a tie.
               if (int'(dist_norm_s) <= SYNC_ERR) begin
                  state_s = ST_VERIFY;
                  inv_s   = 1'b0;
                  ptr_s   = PTR_SYNC;
                  acc_s   = '0;
               end else if (INVERT_OK && (int'(dist_inv_s) <= SYNC_ERR)) begin
                  state_s = ST_VERIFY;
                  inv_s   = 1'b1;
                  ptr_s   = PTR_SYNC;
                  acc_s   = '0;
               end else begin
                  state_s = ST_SEARCH;
               end
            end
            ST_VERIFY, ST_LOCKED: begin
               bit_err_s = mismatch_s;
               cnt_bit_s = (state_r == ST_LOCKED);
               cnt_err_s = (state_r == ST_LOCKED) && mismatch_s;
               if (ptr_r == PTR_LAST) begin
                  ptr_s   = '0;
                  acc_s   = '0;
                  frame_s = 1'b1;
                  if (state_r == ST_VERIFY) begin
                     state_s = bad_frame_s ? ST_SEARCH : ST_LOCKED;
                     bad_s   = '0;
                  end else if (bad_frame_s) begin
                     if (int'(bad_r) + 1 >= LOSS_FRAMES) begin
                        state_s = ST_SEARCH;
                        bad_s   = '0;
                     end else begin
                        bad_s = bad_r + BAD_ONE;
                     end
                  end else begin
                     bad_s = '0;
                  end
               end else begin
                  ptr_s = ptr_r + PTR_ONE;
                  acc_s = acc_inc_s;
               end
            end
            default: begin
               state_s = ST_SEARCH;
            end
         endcase
      end else begin
         sreg_s = sreg_r;
      end

      // A clear takes precedence over any increment landing in the same cycle.
      if (clr_i) begin
         tot_bits_s = '0;
         tot_err_s  = '0;
         fec_s      = '0;
      end else begin
         tot_bits_s = (cnt_bit_s && (tot_bits_r != CNT_MAX)) ? tot_bits_r + CNT_ONE : tot_bits_r;
         tot_err_s  = (cnt_err_s && (tot_err_r != CNT_MAX)) ? tot_err_r + CNT_ONE : tot_err_r;
         fec_s      = frame_s ? acc_inc_s : fec_r;
      end

      locked_s = (state_s == ST_LOCKED);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_SEARCH;
         sreg_r     <= '0;
         ptr_r      <= '0;
         inv_r      <= 1'b0;
         acc_r      <= '0;
         bad_r      <= '0;
         bit_err_r  <= 1'b0;
         frame_r    <= 1'b0;
         locked_r   <= 1'b0;
         fec_r      <= '0;
         tot_bits_r <= '0;
         tot_err_r  <= '0;
      end else begin
         state_r    <= state_s;
         sreg_r     <= sreg_s;
         ptr_r      <= ptr_s;
         inv_r      <= inv_s;
         acc_r      <= acc_s;
         bad_r      <= bad_s;
         bit_err_r  <= bit_err_s;
         frame_r    <= frame_s;
         locked_r   <= locked_s;
         fec_r      <= fec_s;
         tot_bits_r <= tot_bits_s;
         tot_err_r  <= tot_err_s;
      end
   end

   assign state_o         = state_r;
   assign locked_o        = locked_r;
   assign inverted_o      = inv_r;
   assign bit_err_o       = bit_err_r;
   assign frame_o         = frame_r;
   assign frame_err_cnt_o = fec_r;
   assign tot_bits_o      = tot_bits_r;
   assign tot_err_o       = tot_err_r;

endmodule

// File: tb/tb_msk_frame_sync_ber.sv
// Self-checking bench for msk_frame_sync_ber: per-bit scoreboard of state/polarity/pulses plus
// counter checks for lock, inversion, single error, loss of lock, gapped input, reset and clear.
module tb_msk_frame_sync_ber;

   localparam int FDW    = 256;
   localparam int SYNC_W = 32;
   localparam int CNT_W  = 32;
   localparam int EW     = $clog2(FDW + 1);

   function automatic logic [FDW-1:0] gen_pat();
      logic [FDW-1:0] p;
      logic [31:0]    x;
      p = '0;
      x = 32'h1234_5678;
      for (int i = 0; i < FDW; i++) begin
         x = x ^ (x << 13);
         x = x ^ (x >> 17);
         x = x ^ (x << 5);
         p[i] = x[0];
      end
      return p;
   endfunction

   localparam logic [FDW-1:0] PAT = gen_pat();

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             data_i = 1'b0;
   logic             data_val_i = 1'b0;
   logic             clr_i = 1'b0;
   logic [1:0]       state_o;
   logic             locked_o;
   logic             inverted_o;
   logic             bit_err_o;
   logic             frame_o;
   logic [EW-1:0]    frame_err_cnt_o;
   logic [CNT_W-1:0] tot_bits_o;
   logic [CNT_W-1:0] tot_err_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [1:0] st;
      logic       inv;
      logic       berr;
      logic       frm;
   } exp_t;

   exp_t sb[$];

   msk_frame_sync_ber #(
      .FDW(FDW), .FIXED_DATA(PAT), .SYNC_W(SYNC_W), .SYNC_ERR(0), .INVERT_OK(1'b1),
      .LOSS_THRESH(16), .LOSS_FRAMES(2), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .data_i(data_i), .data_val_i(data_val_i), .clr_i(clr_i),
      .state_o(state_o), .locked_o(locked_o), .inverted_o(inverted_o), .bit_err_o(bit_err_o),
      .frame_o(frame_o), .frame_err_cnt_o(frame_err_cnt_o), .tot_bits_o(tot_bits_o),
      .tot_err_o(tot_err_o)
   );

   always #5 clk = ~clk;

   function automatic logic pat_bit(input int idx);
      logic [FDW-1:0] p;
      p = PAT;
      return p[FDW-1-(idx % FDW)];
   endfunction

   function automatic logic [1:0] exp_state(input int n, input int ns);
      if (n < ns) return 2'd0;
      else if (n < ns + FDW - SYNC_W) return 2'd1;
      else return 2'd2;
   endfunction

   function automatic logic is_frame(input int n, input int ns);
      int nl;
      nl = ns + FDW - SYNC_W;
      return (n >= nl) && (((n - nl) % FDW) == 0);
   endfunction

   task automatic drive_bit(input logic b, input logic v, input logic c);
      data_i     = b;
      data_val_i = v;
      clr_i      = c;
      @(posedge clk);
      #1;
      data_val_i = 1'b0;
      clr_i      = 1'b0;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      data_val_i = 1'b0;
      clr_i      = 1'b0;
      data_i     = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [78:0] got;
      rst = 1'b1;
      @(posedge clk);
      #1;
      got = {state_o, locked_o, inverted_o, bit_err_o, frame_o, frame_err_cnt_o, tot_bits_o, tot_err_o};
      checks++;
      if (got !== 79'd0) begin
         errors++;
         $display("FAIL reset_state: got %h required 0", got);
      end
      rst = 1'b0;
   endtask

   task automatic test_lock();
      exp_t e, got;
      int   frames_locked;
      logic [1:0] prev_st;
      frames_locked = 0;
      prev_st = 2'd0;
      do_reset();
      for (int n = 1; n <= 3 * FDW; n++) begin
         e = '{st: exp_state(n, 32), inv: 1'b0, berr: 1'b0, frm: is_frame(n, 32)};
         sb.push_back(e);
         drive_bit(pat_bit(n - 1), 1'b1, 1'b0);
         e = sb.pop_front();
         got = {state_o, inverted_o, bit_err_o, frame_o};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL lock_bit%0d: got %b required %b", n, got, e);
         end
         if (frame_o && prev_st == 2'd2) frames_locked++;
         prev_st = state_o;
      end
      checks++;
      if (tot_bits_o !== 32'd512 || tot_err_o !== 32'd0 || !locked_o || frames_locked != 2) begin
         errors++;
         $display("FAIL lock_totals: bits %0d err %0d locked %b frames %0d required 512 0 1 2",
                  tot_bits_o, tot_err_o, locked_o, frames_locked);
      end
   endtask

   task automatic test_inverted();
      exp_t e, got;
      do_reset();
      for (int n = 1; n <= 3 * FDW; n++) begin
         e = '{st: exp_state(n, 32), inv: (n >= 32), berr: 1'b0, frm: is_frame(n, 32)};
         sb.push_back(e);
         drive_bit(~pat_bit(n - 1), 1'b1, 1'b0);
         e = sb.pop_front();
         got = {state_o, inverted_o, bit_err_o, frame_o};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL inv_bit%0d: got %b required %b", n, got, e);
         end
      end
      checks++;
      if (tot_bits_o !== 32'd512 || tot_err_o !== 32'd0 || !inverted_o || !locked_o) begin
         errors++;
         $display("FAIL inv_totals: bits %0d err %0d inv %b locked %b required 512 0 1 1",
                  tot_bits_o, tot_err_o, inverted_o, locked_o);
      end
   endtask

   task automatic test_bit_error();
      exp_t e, got;
      do_reset();
      for (int n = 1; n <= 4 * FDW; n++) begin
         e = '{st: exp_state(n, 32), inv: 1'b0, berr: (n == 613), frm: is_frame(n, 32)};
         sb.push_back(e);
         drive_bit(pat_bit(n - 1) ^ (n == 613), 1'b1, 1'b0);
         e = sb.pop_front();
         got = {state_o, inverted_o, bit_err_o, frame_o};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL err_bit%0d: got %b required %b", n, got, e);
         end
         if (n == 768) begin
            checks++;
            if (frame_err_cnt_o !== 9'd1 || tot_err_o !== 32'd1) begin
               errors++;
               $display("FAIL err_wrap: fec %0d tot_err %0d required 1 1", frame_err_cnt_o, tot_err_o);
            end
         end
      end
      checks++;
      if (frame_err_cnt_o !== 9'd0 || tot_err_o !== 32'd1 || tot_bits_o !== 32'd768 || !locked_o) begin
         errors++;
         $display("FAIL err_totals: fec %0d err %0d bits %0d locked %b required 0 1 768 1",
                  frame_err_cnt_o, tot_err_o, tot_bits_o, locked_o);
      end
   endtask

   task automatic test_loss();
      exp_t e, got;
      logic b, mm;
      int   err3, err4;
      err3 = 0;
      err4 = 0;
      do_reset();
      for (int n = 1; n <= 4 * FDW + 64; n++) begin
         b  = (n <= 2 * FDW) ? pat_bit(n - 1) : 1'($urandom_range(0, 1));
         mm = (n > 2 * FDW) && (n <= 4 * FDW) && (b != pat_bit(n - 1));
         if (mm && n <= 3 * FDW) err3++;
         if (mm && n > 3 * FDW) err4++;
         e.st   = (n >= 4 * FDW) ? 2'd0 : exp_state(n, 32);
         e.inv  = 1'b0;
         e.berr = mm;
         e.frm  = (n <= 4 * FDW) && is_frame(n, 32);
         sb.push_back(e);
         drive_bit(b, 1'b1, 1'b0);
         e = sb.pop_front();
         got = {state_o, inverted_o, bit_err_o, frame_o};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL loss_bit%0d: got %b required %b", n, got, e);
         end
         if (n == 3 * FDW) begin
            checks++;
            if (frame_err_cnt_o !== 9'(err3)) begin
               errors++;
               $display("FAIL loss_fec3: got %0d required %0d", frame_err_cnt_o, err3);
            end
         end
      end
      checks++;
      if (locked_o || tot_bits_o !== 32'd768 || tot_err_o !== 32'(err3 + err4) ||
          frame_err_cnt_o !== 9'(err4)) begin
         errors++;
         $display("FAIL loss_totals: locked %b bits %0d err %0d fec %0d required 0 768 %0d %0d",
                  locked_o, tot_bits_o, tot_err_o, frame_err_cnt_o, err3 + err4, err4);
      end
   endtask

   task automatic test_gaps();
      exp_t e, got;
      int   gaps;
      do_reset();
      for (int n = 1; n <= 435 + FDW; n++) begin
         gaps = 0;
         while ($urandom_range(0, 1) == 1 && gaps < 4) begin
            gaps++;
            e = '{st: exp_state(n - 1, 211), inv: 1'b0, berr: 1'b0, frm: 1'b0};
            sb.push_back(e);
            drive_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            e = sb.pop_front();
            got = {state_o, inverted_o, bit_err_o, frame_o};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL gap_before%0d: got %b required %b", n, got, e);
            end
         end
         e = '{st: exp_state(n, 211), inv: 1'b0, berr: 1'b0, frm: is_frame(n, 211)};
         sb.push_back(e);
         drive_bit(pat_bit(77 + n - 1), 1'b1, 1'b0);
         e = sb.pop_front();
         got = {state_o, inverted_o, bit_err_o, frame_o};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL gap_bit%0d: got %b required %b", n, got, e);
         end
      end
      checks++;
      if (!locked_o || tot_bits_o !== 32'd256 || tot_err_o !== 32'd0) begin
         errors++;
         $display("FAIL gap_totals: locked %b bits %0d err %0d required 1 256 0",
                  locked_o, tot_bits_o, tot_err_o);
      end
   endtask

   task automatic test_reset_clear();
      exp_t e, got;
      logic [78:0] all_out;
      do_reset();
      for (int n = 1; n <= 300; n++) drive_bit(pat_bit(n - 1), 1'b1, 1'b0);
      rst = 1'b1;
      #1;
      all_out = {state_o, locked_o, inverted_o, bit_err_o, frame_o, frame_err_cnt_o, tot_bits_o, tot_err_o};
      checks++;
      if (all_out !== 79'd0) begin
         errors++;
         $display("FAIL mid_reset: got %h required 0", all_out);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int n = 1; n <= 2 * FDW; n++) begin
         e = '{st: exp_state(n, 32), inv: 1'b0, berr: (n == 301 || n == 302), frm: is_frame(n, 32)};
         sb.push_back(e);
         drive_bit(pat_bit(n - 1) ^ (n == 301 || n == 302), 1'b1, n == 301);
         e = sb.pop_front();
         got = {state_o, inverted_o, bit_err_o, frame_o};
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL clr_bit%0d: got %b required %b", n, got, e);
         end
         if (n == 301 || n == 302) begin
            checks++;
            if (tot_err_o !== 32'(n - 301) || tot_bits_o !== 32'(n - 301)) begin
               errors++;
               $display("FAIL clr_cnt%0d: err %0d bits %0d required %0d %0d",
                        n, tot_err_o, tot_bits_o, n - 301, n - 301);
            end
         end
      end
      checks++;
      if (frame_err_cnt_o !== 9'd2 || tot_bits_o !== 32'd211 || tot_err_o !== 32'd1) begin
         errors++;
         $display("FAIL clr_frame: fec %0d bits %0d err %0d required 2 211 1",
                  frame_err_cnt_o, tot_bits_o, tot_err_o);
      end
      drive_bit(1'b0, 1'b0, 1'b1);
      checks++;
      if (frame_err_cnt_o !== 9'd0 || tot_bits_o !== 32'd0 || tot_err_o !== 32'd0 || !locked_o) begin
         errors++;
         $display("FAIL clr_idle: fec %0d bits %0d err %0d locked %b required 0 0 0 1",
                  frame_err_cnt_o, tot_bits_o, tot_err_o, locked_o);
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_inverted();
      test_bit_error();
      test_loss();
      test_gaps();
      test_reset_clear();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
